// File: rtl/parser_pkg.sv
// ---------------------------------------------------------------------------
// parser_pkg
// Shared constants and types for the parser's type-rule lookup stage.
//   - *_DEF localparams : default sizing of the type-rule table
//   - type_vec_t        : TYPE_NUM fields of TYPE_WIDTH bits
//   - key_offset_vec_t  : KEY_FILED_NUM offsets of KEY_OFFSET_WIDTH bits
//   - rule_entry_t      : one table entry (valid, data, mask, keyOffset)
//   - idWidth()         : index width for an n-entry table, never below 1
// ---------------------------------------------------------------------------
package parser_pkg;

  localparam int TYPE_NUM_DEF         = 4;
  localparam int TYPE_WIDTH_DEF       = 8;
  localparam int KEY_OFFSET_WIDTH_DEF = 6;
  localparam int KEY_FILED_NUM_DEF    = 8;
  localparam int RULE_NUM_DEF         = 4;

  typedef logic [TYPE_NUM_DEF-1:0][TYPE_WIDTH_DEF-1:0] type_vec_t;
  typedef logic [KEY_FILED_NUM_DEF-1:0][KEY_OFFSET_WIDTH_DEF-1:0] key_offset_vec_t;

  typedef struct packed {
    logic            valid;
    type_vec_t       data;
    type_vec_t       mask;
    key_offset_vec_t keyOffset;
  } rule_entry_t;

  // A single-entry table still needs a one-bit index.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rule_prio_enc.sv
// ---------------------------------------------------------------------------
// rule_prio_enc
// Combinational priority encoder; the lowest set bit wins.
// Ports:
//   hit_i [N-1:0] : per-rule hit vector
//   any_o         : at least one bit of hit_i is set
//   idx_o [W-1:0] : index of the lowest set bit, 0 when nothing is set
// ---------------------------------------------------------------------------
module rule_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] hit_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  // Scan from the top down so the last assignment is the lowest index.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_i[i]) begin
        any_o = 1'b1;
        idx_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/type_rule_lookup.sv
// ---------------------------------------------------------------------------
// type_rule_lookup
// Holds the type-rule table and matches every extracted type vector against
// all rules in parallel. A two-stage pipeline returns the winning rule's
// key-field offsets to the key extractor, with valid/ready backpressure.
// Optional build macro: TYPE_RULE_HIT_CNT_EN adds per-rule hit counters and
// a miss counter, read through i_cnt_rd_idx / o_cnt_rd_data.
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_typeRule_*           : table write strobe (one bit per rule) and data
//   i_type_valid/data      : lookup request
//   o_type_ready           : request accepted when valid & ready
//   o_key_valid/hit/ruleID : lookup result
//   o_key_offset           : winning rule's key offsets (0 on miss)
//   i_key_ready            : downstream accepts the result
//   i_cnt_rd_idx           : counter select (macro builds only)
//   o_cnt_rd_data          : registered counter value (macro builds only)
// ---------------------------------------------------------------------------
module type_rule_lookup
  import parser_pkg::*;
#(
  parameter int TYPE_NUM         = TYPE_NUM_DEF,
  parameter int TYPE_WIDTH       = TYPE_WIDTH_DEF,
  parameter int KEY_OFFSET_WIDTH = KEY_OFFSET_WIDTH_DEF,
  parameter int KEY_FILED_NUM    = KEY_FILED_NUM_DEF,
  parameter int RULE_NUM         = RULE_NUM_DEF,
  parameter int RULE_ID_WIDTH    = idWidth(RULE_NUM)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [RULE_NUM-1:0]                       i_typeRule_wren,
  input  logic                                      i_typeRule_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_typeRule_typeData,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_typeRule_typeMask,
  input  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] i_typeRule_keyOffset,
  input  logic                                      i_type_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_type_data,
  output logic                                      o_type_ready,
  output logic                                      o_key_valid,
  output logic                                      o_key_hit,
  output logic [RULE_ID_WIDTH-1:0]                  o_key_ruleID,
  output logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] o_key_offset,
`ifdef TYPE_RULE_HIT_CNT_EN
  input  logic [RULE_ID_WIDTH:0]                    i_cnt_rd_idx,
  output logic [31:0]                               o_cnt_rd_data,
`endif
  input  logic                                      i_key_ready
);

  localparam int TW = TYPE_NUM * TYPE_WIDTH;
  localparam int OW = KEY_FILED_NUM * KEY_OFFSET_WIDTH;

  logic          ruleValid_q  [RULE_NUM];
  logic [TW-1:0] ruleData_q   [RULE_NUM];
  logic [TW-1:0] ruleMask_q   [RULE_NUM];
  logic [OW-1:0] ruleOffset_q [RULE_NUM];

  logic [RULE_NUM-1:0]      hitVec;
  logic                     en;
  logic                     s1Valid_q;
  logic [RULE_NUM-1:0]      s1Hit_q;
  logic                     encAny;
  logic [RULE_ID_WIDTH-1:0] encIdx;

  logic                     keyValid_q;
  logic                     keyHit_q, keyHit_d;
  logic [RULE_ID_WIDTH-1:0] keyRuleId_q, keyRuleId_d;
  logic [OW-1:0]            keyOffset_q, keyOffset_d;

  // Both stages advance together whenever the output slot is empty or drained.
  assign en           = ~keyValid_q | i_key_ready;
  assign o_type_ready = en;

  // Table writes ignore backpressure; every flagged entry takes the same data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        ruleValid_q[r]  <= 1'b0;
        ruleData_q[r]   <= '0;
        ruleMask_q[r]   <= '0;
        ruleOffset_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (i_typeRule_wren[r]) begin
          ruleValid_q[r]  <= i_typeRule_valid;
          ruleData_q[r]   <= i_typeRule_typeData;
          ruleMask_q[r]   <= i_typeRule_typeMask;
          ruleOffset_q[r] <= i_typeRule_keyOffset;
        end
      end
    end
  end

  // Masked compare across the whole vector equals the per-field compare,
  // since each field's mask bits only touch that field.
  always_comb begin
    hitVec = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      hitVec[r] = ruleValid_q[r] &
                  (((i_type_data ^ ruleData_q[r]) & ruleMask_q[r]) == '0);
    end
  end

  // Stage 1: hits are taken against the table as it stood before this edge.
  // Bubbles carry an all-zero hit vector so idle outputs stay clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1Valid_q <= 1'b0;
      s1Hit_q   <= '0;
    end else if (en) begin
      s1Valid_q <= i_type_valid;
      s1Hit_q   <= i_type_valid ? hitVec : '0;
    end
  end

  rule_prio_enc #(
    .N (RULE_NUM),
    .W (RULE_ID_WIDTH)
  ) u_prio_enc (
    .hit_i (s1Hit_q),
    .any_o (encAny),
    .idx_o (encIdx)
  );

  // Offsets are read at stage 2, so a rewrite between stages shows up here.
  always_comb begin
    keyHit_d    = encAny;
    keyRuleId_d = encIdx;
    keyOffset_d = encAny ? ruleOffset_q[encIdx] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      keyValid_q  <= 1'b0;
      keyHit_q    <= 1'b0;
      keyRuleId_q <= '0;
      keyOffset_q <= '0;
    end else if (en) begin
      keyValid_q  <= s1Valid_q;
      keyHit_q    <= keyHit_d;
      keyRuleId_q <= keyRuleId_d;
      keyOffset_q <= keyOffset_d;
    end
  end

  assign o_key_valid  = keyValid_q;
  assign o_key_hit    = keyHit_q;
  assign o_key_ruleID = keyRuleId_q;
  assign o_key_offset = keyOffset_q;

`ifdef TYPE_RULE_HIT_CNT_EN
  localparam logic [RULE_ID_WIDTH:0] RULE_NUM_IDX = (RULE_ID_WIDTH + 1)'(RULE_NUM);

  logic [31:0] hitCnt_q [RULE_NUM];
  logic [31:0] missCnt_q;
  logic [31:0] cntRdData_q, cntRdData_d;
  logic        resultFire;

  assign resultFire = keyValid_q & i_key_ready;

  // Counters count delivered results only; rewriting a rule restarts its count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        hitCnt_q[r] <= '0;
      end
      missCnt_q <= '0;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (i_typeRule_wren[r]) begin
          hitCnt_q[r] <= '0;
        end else if (resultFire && keyHit_q && keyRuleId_q == RULE_ID_WIDTH'(r) &&
                     hitCnt_q[r] != 32'hFFFF_FFFF) begin
          hitCnt_q[r] <= hitCnt_q[r] + 32'd1;
        end
      end
      if (resultFire && !keyHit_q && missCnt_q != 32'hFFFF_FFFF) begin
        missCnt_q <= missCnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    cntRdData_d = '0;
    if (i_cnt_rd_idx < RULE_NUM_IDX) begin
      cntRdData_d = hitCnt_q[i_cnt_rd_idx[RULE_ID_WIDTH-1:0]];
    end else if (i_cnt_rd_idx == RULE_NUM_IDX) begin
      cntRdData_d = missCnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cntRdData_q <= '0;
    end else begin
      cntRdData_q <= cntRdData_d;
    end
  end

  assign o_cnt_rd_data = cntRdData_q;
`endif

endmodule

// File: tb/tb_type_rule_lookup.sv
// ---------------------------------------------------------------------------
// tb_type_rule_lookup
// Directed bench for type_rule_lookup with hand-computed expected results.
// Build with TYPE_RULE_HIT_CNT_EN defined to also exercise the hit counters.
// ---------------------------------------------------------------------------
module tb_type_rule_lookup;

  localparam int TW  = 32;
  localparam int OW  = 48;
  localparam int RN  = 4;
  localparam int IDW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [RN-1:0] i_typeRule_wren;
  logic          i_typeRule_valid;
  logic [TW-1:0] i_typeRule_typeData;
  logic [TW-1:0] i_typeRule_typeMask;
  logic [OW-1:0] i_typeRule_keyOffset;
  logic          i_type_valid;
  logic [TW-1:0] i_type_data;
  logic          o_type_ready;
  logic          o_key_valid;
  logic          o_key_hit;
  logic [IDW-1:0] o_key_ruleID;
  logic [OW-1:0] o_key_offset;
  logic          i_key_ready;
`ifdef TYPE_RULE_HIT_CNT_EN
  logic [IDW:0]  i_cnt_rd_idx;
  logic [31:0]   o_cnt_rd_data;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // Free-running 100 MHz clock.
  always #5 i_clk = ~i_clk;

  type_rule_lookup dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_typeRule_wren      (i_typeRule_wren),
    .i_typeRule_valid     (i_typeRule_valid),
    .i_typeRule_typeData  (i_typeRule_typeData),
    .i_typeRule_typeMask  (i_typeRule_typeMask),
    .i_typeRule_keyOffset (i_typeRule_keyOffset),
    .i_type_valid         (i_type_valid),
    .i_type_data          (i_type_data),
    .o_type_ready         (o_type_ready),
    .o_key_valid          (o_key_valid),
    .o_key_hit            (o_key_hit),
    .o_key_ruleID         (o_key_ruleID),
    .o_key_offset         (o_key_offset),
`ifdef TYPE_RULE_HIT_CNT_EN
    .i_cnt_rd_idx         (i_cnt_rd_idx),
    .o_cnt_rd_data        (o_cnt_rd_data),
`endif
    .i_key_ready          (i_key_ready)
  );

  // Offsets 1..8, field 0 in the low bits.
  function automatic logic [OW-1:0] offSeq();
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*6 +: 6] = 6'(k + 1);
    return v;
  endfunction

  function automatic logic [OW-1:0] offAll(input logic [5:0] f);
    logic [OW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*6 +: 6] = f;
    return v;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [TW-1:0] data);
    i_type_valid = valid;
    i_type_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic hit,
                             input logic [IDW-1:0] id, input logic [OW-1:0] off);
    checkOutput({tag, ".valid"},  64'(o_key_valid),  64'd1);
    checkOutput({tag, ".hit"},    64'(o_key_hit),    64'(hit));
    checkOutput({tag, ".ruleID"}, 64'(o_key_ruleID), 64'(id));
    checkOutput({tag, ".offset"}, 64'(o_key_offset), 64'(off));
  endtask

  task automatic writeRule(input logic [RN-1:0] wren, input logic valid,
                           input logic [TW-1:0] data, input logic [TW-1:0] mask,
                           input logic [OW-1:0] off);
    i_typeRule_wren      = wren;
    i_typeRule_valid     = valid;
    i_typeRule_typeData  = data;
    i_typeRule_typeMask  = mask;
    i_typeRule_keyOffset = off;
    tick();
    i_typeRule_wren = '0;
  endtask

  // Single lookup, no stall: result appears two edges after acceptance.
  task automatic lookup(input logic [TW-1:0] data);
    applyStimulus(1'b1, data);
    tick();
    applyStimulus(1'b0, '0);
    tick();
  endtask

  initial begin
    i_rst_n              = 1'b0;
    i_typeRule_wren      = '0;
    i_typeRule_valid     = 1'b0;
    i_typeRule_typeData  = '0;
    i_typeRule_typeMask  = '0;
    i_typeRule_keyOffset = '0;
    i_key_ready          = 1'b1;
    applyStimulus(1'b0, '0);
`ifdef TYPE_RULE_HIT_CNT_EN
    i_cnt_rd_idx = '0;
`endif
    repeat (3) @(posedge i_clk);
    #1;

    checkOutput("reset.valid",  64'(o_key_valid),  64'd0);
    checkOutput("reset.hit",    64'(o_key_hit),    64'd0);
    checkOutput("reset.ruleID", 64'(o_key_ruleID), 64'd0);
    checkOutput("reset.offset", 64'(o_key_offset), 64'd0);
    checkOutput("reset.ready",  64'(o_type_ready), 64'd1);
    i_rst_n = 1'b1;
    tick();

    // Basic hit on rule 0.
    writeRule(4'b0001, 1'b1, 32'h0800_0000, 32'hFF00_0000, offSeq());
    lookup(32'h0811_2233);
    checkResult("rule0", 1'b1, 2'd0, offSeq());
    tick();
    checkOutput("rule0.drain", 64'(o_key_valid), 64'd0);

    // Rules 1 and 3 both match; the lower index wins.
    writeRule(4'b0010, 1'b1, 32'h86DD_0000, 32'hFFFF_0000, offAll(6'd5));
    writeRule(4'b1000, 1'b1, 32'h86DD_0000, 32'hFFFF_0000, offAll(6'd9));
    lookup(32'h86DD_1234);
    checkResult("prio", 1'b1, 2'd1, offAll(6'd5));

    // An invalid rule with a match-all mask must still miss.
    writeRule(4'b0100, 1'b0, 32'h0000_0000, 32'h0000_0000, offAll(6'd7));
    lookup(32'h1234_5678);
    checkResult("miss", 1'b0, 2'd0, '0);

    // Back-to-back A,B,C with a three-cycle stall while A is presented.
    applyStimulus(1'b1, 32'h08AA_AAAA);
    tick();
    applyStimulus(1'b1, 32'h86DD_0000);
    tick();
    checkResult("streamA", 1'b1, 2'd0, offSeq());
    i_key_ready = 1'b0;
    applyStimulus(1'b1, 32'h1234_5678);
    #1;
    checkOutput("stall.ready", 64'(o_type_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkResult("stallA", 1'b1, 2'd0, offSeq());
      checkOutput("stall.ready", 64'(o_type_ready), 64'd0);
    end
    i_key_ready = 1'b1;
    #1;
    checkOutput("release.ready", 64'(o_type_ready), 64'd1);
    tick();
    applyStimulus(1'b0, '0);
    checkResult("streamB", 1'b1, 2'd1, offAll(6'd5));
    tick();
    checkResult("streamC", 1'b0, 2'd0, '0);
    tick();
    checkOutput("stream.drain", 64'(o_key_valid), 64'd0);

    // Rule 2 written at the same edge its matching lookup enters stage 1.
    i_typeRule_wren      = 4'b0100;
    i_typeRule_valid     = 1'b1;
    i_typeRule_typeData  = 32'hC000_0000;
    i_typeRule_typeMask  = 32'hF000_0000;
    i_typeRule_keyOffset = offAll(6'd3);
    applyStimulus(1'b1, 32'hC100_0000);
    tick();
    i_typeRule_wren = '0;
    applyStimulus(1'b0, '0);
    tick();
    checkResult("hazard.old", 1'b0, 2'd0, '0);
    lookup(32'hC100_0000);
    checkResult("hazard.new", 1'b1, 2'd2, offAll(6'd3));

    // Reset with one result on the output and another lookup in stage 1.
    applyStimulus(1'b1, 32'h0800_0000);
    tick();
    applyStimulus(1'b1, 32'hC200_0000);
    tick();
    applyStimulus(1'b0, '0);
    checkOutput("midrst.pre", 64'(o_key_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midrst.valid",  64'(o_key_valid),  64'd0);
    checkOutput("midrst.hit",    64'(o_key_hit),    64'd0);
    checkOutput("midrst.offset", 64'(o_key_offset), 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    checkOutput("midrst.flushed", 64'(o_key_valid), 64'd0);

`ifdef TYPE_RULE_HIT_CNT_EN
    // Five hits on rule 0, then two misses, then drain the pipeline.
    writeRule(4'b0001, 1'b1, 32'h0800_0000, 32'hFF00_0000, offSeq());
    applyStimulus(1'b1, 32'h0800_0000);
    repeat (5) tick();
    applyStimulus(1'b1, 32'h1234_5678);
    repeat (2) tick();
    applyStimulus(1'b0, '0);
    repeat (4) tick();
    i_cnt_rd_idx = 3'd0;
    tick();
    checkOutput("cnt.rule0", 64'(o_cnt_rd_data), 64'd5);
    i_cnt_rd_idx = 3'd4;
    tick();
    checkOutput("cnt.miss", 64'(o_cnt_rd_data), 64'd2);
    i_cnt_rd_idx = 3'd7;
    tick();
    checkOutput("cnt.badidx", 64'(o_cnt_rd_data), 64'd0);
    writeRule(4'b0001, 1'b1, 32'h0800_0000, 32'hFF00_0000, offSeq());
    i_cnt_rd_idx = 3'd0;
    tick();
    checkOutput("cnt.cleared", 64'(o_cnt_rd_data), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
